two_step_seq: RTL and testbench

Conversion sequencer for the two-step (3-bit coarse + 3-bit fine) ADC. It drives the track/hold, coarse and fine comparator latches, and the residue DAC. It encodes both 7-bit thermometer comparator banks and emits the stage codes on `msb_o`/`lsb_o` with the fixed one-cycle skew that the downstream time-alignment stage expects. `align_vld_o` flags the cycle in which the aligned 6-bit word is valid at the aligner output.

---
 rtl/two_step_seq_if.sv | 30 +++
 rtl/two_step_seq.sv | 184 ++++++++++++++++++
 tb/tb_two_step_seq.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/two_step_seq_if.sv
// two_step_seq_if
//   Bundles the conversion request, comparator banks and sequencer outputs
//   of the two-step ADC sequencer.
//   master : drives start_i / coarse_therm_i / fine_therm_i, observes the rest
//   slave  : the sequencer itself
interface two_step_seq_if;
   logic       start_i;
   logic [6:0] coarse_therm_i;
   logic [6:0] fine_therm_i;
   logic       busy_o;
   logic       sample_o;
   logic       coarse_latch_o;
   logic       fine_latch_o;
   logic [2:0] dac_code_o;
   logic [2:0] msb_o;
   logic [2:0] lsb_o;
   logic       align_vld_o;

   modport master (
      output start_i, coarse_therm_i, fine_therm_i,
      input  busy_o, sample_o, coarse_latch_o, fine_latch_o,
             dac_code_o, msb_o, lsb_o, align_vld_o
   );

   modport slave (
      input  start_i, coarse_therm_i, fine_therm_i,
      output busy_o, sample_o, coarse_latch_o, fine_latch_o,
             dac_code_o, msb_o, lsb_o, align_vld_o
   );
endinterface

// File: rtl/two_step_seq.sv
// two_step_seq
//   Conversion sequencer for the 3-bit coarse + 3-bit fine two-step ADC.
//   Drives track/hold, coarse/fine comparator strobes and the residue DAC,
//   encodes both thermometer banks and presents msb/lsb with a one-cycle skew
//   for the downstream aligner; align_vld_o marks the aligned word.
//
//   Parameters : SAMPLE_CYC (1..15) track cycles, SETTLE_CYC (1..15) residue
//                settle cycles.
//   Ports      : clk_i, reset_ni (async, active low), bus (two_step_seq_if.slave)
//   Macro      : TWO_STEP_BUBBLE_CORR_EN enables a 3-input majority bubble
//                filter on each thermometer bank ahead of the encoder.
//
//   state  | meaning
//   IDLE   | waiting for start_i
//   SAMPLE | track/hold tracking, SAMPLE_CYC cycles
//   CLATCH | coarse strobe; coarse code captured at closing edge
//   SETTLE | residue DAC/amp settling, SETTLE_CYC cycles
//   FLATCH | fine strobe; fine code captured, msb updated at closing edge
//   LOUT   | lsb updated and vld flag set at closing edge; start_i re-sampled
module two_step_seq #(
   parameter int unsigned SAMPLE_CYC = 2,
   parameter int unsigned SETTLE_CYC = 2
) (
   input logic          clk_i,
   input logic          reset_ni,
   two_step_seq_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SAMPLE = 3'd1,
      CLATCH = 3'd2,
      SETTLE = 3'd3,
      FLATCH = 3'd4,
      LOUT   = 3'd5
   } state_t;

   localparam logic [3:0] SAMPLE_LOAD = 4'(SAMPLE_CYC - 1);
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

   function automatic logic [2:0] therm_enc(input logic [6:0] t);
      logic [2:0] code;
      if      (t[6]) code = 3'd7;
      else if (t[5]) code = 3'd6;
      else if (t[4]) code = 3'd5;
      else if (t[3]) code = 3'd4;
      else if (t[2]) code = 3'd3;
      else if (t[1]) code = 3'd2;
      else if (t[0]) code = 3'd1;
      else           code = 3'd0;
      return code;
   endfunction

   logic [6:0] coarse_filt;
   logic [6:0] fine_filt;

`ifdef TWO_STEP_BUBBLE_CORR_EN
   // Below threshold 0 counts as set, above threshold 6 counts as clear.
   function automatic logic [6:0] bubble_fix(input logic [6:0] t);
      logic [8:0] x;
      logic [6:0] f;
      x = {1'b0, t, 1'b1};
      for (int k = 0; k < 7; k++) begin
         f[k] = (x[k] & x[k+1]) | (x[k] & x[k+2]) | (x[k+1] & x[k+2]);
      end
      return f;
   endfunction

   assign coarse_filt = bubble_fix(bus.coarse_therm_i);
   assign fine_filt   = bubble_fix(bus.fine_therm_i);
`else
   assign coarse_filt = bus.coarse_therm_i;
   assign fine_filt   = bus.fine_therm_i;
`endif

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [2:0] coarse_q, coarse_d;
   logic [2:0] fine_q, fine_d;
   logic [2:0] msb_q, msb_d;
   logic [2:0] lsb_q, lsb_d;
   logic       vld_q, vld_d;
   logic       align_vld_q, align_vld_d;
   logic       busy_q, busy_d;
   logic       sample_q, sample_d;
   logic       clatch_q, clatch_d;
   logic       flatch_q, flatch_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      coarse_d    = coarse_q;
      fine_d      = fine_q;
      msb_d       = msb_q;
      lsb_d       = lsb_q;
      vld_d       = 1'b0;
      align_vld_d = vld_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               state_d = SAMPLE;
               cnt_d   = SAMPLE_LOAD;
            end
         end
         SAMPLE: begin
            if (cnt_q == 4'd0) state_d = CLATCH;
            else               cnt_d   = cnt_q - 4'd1;
         end
         CLATCH: begin
            coarse_d = therm_enc(coarse_filt);
            state_d  = SETTLE;
            cnt_d    = SETTLE_LOAD;
         end
         SETTLE: begin
            if (cnt_q == 4'd0) state_d = FLATCH;
            else               cnt_d   = cnt_q - 4'd1;
         end
         FLATCH: begin
            fine_d  = therm_enc(fine_filt);
            msb_d   = coarse_q;
            state_d = LOUT;
         end
         LOUT: begin
            lsb_d = fine_q;
            vld_d = 1'b1;
            if (bus.start_i) begin
               state_d = SAMPLE;
               cnt_d   = SAMPLE_LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Strobes are decoded from the next state so they are flop outputs
      // that line up exactly with the state they belong to.
      busy_d   = (state_d != IDLE);
      sample_d = (state_d == SAMPLE);
      clatch_d = (state_d == CLATCH);
      flatch_d = (state_d == FLATCH);
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         coarse_q    <= 3'd0;
         fine_q      <= 3'd0;
         msb_q       <= 3'd0;
         lsb_q       <= 3'd0;
         vld_q       <= 1'b0;
         align_vld_q <= 1'b0;
         busy_q      <= 1'b0;
         sample_q    <= 1'b0;
         clatch_q    <= 1'b0;
         flatch_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         coarse_q    <= coarse_d;
         fine_q      <= fine_d;
         msb_q       <= msb_d;
         lsb_q       <= lsb_d;
         vld_q       <= vld_d;
         align_vld_q <= align_vld_d;
         busy_q      <= busy_d;
         sample_q    <= sample_d;
         clatch_q    <= clatch_d;
         flatch_q    <= flatch_d;
      end
   end

   assign bus.busy_o         = busy_q;
   assign bus.sample_o       = sample_q;
   assign bus.coarse_latch_o = clatch_q;
   assign bus.fine_latch_o   = flatch_q;
   assign bus.dac_code_o     = coarse_q;
   assign bus.msb_o          = msb_q;
   assign bus.lsb_o          = lsb_q;
   assign bus.align_vld_o    = align_vld_q;

endmodule

// File: tb/tb_two_step_seq.sv
// tb_two_step_seq
//   Two sequencers (default 2/2 and 1/3 timing) share the same stimulus.
//   Expected codes and align_vld cycle stamps are queued at each launch and
//   popped by per-instance monitors whenever align_vld_o is seen.
module tb_two_step_seq;

   localparam int A_S = 2, A_T = 2;
   localparam int B_S = 1, B_T = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [6:0] coarse = 7'd0;
   logic [6:0] fine = 7'd0;

   int cyc = 0;
   int c0 = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0] msb;
      logic [2:0] lsb;
      int         cyc;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   two_step_seq_if if_a ();
   two_step_seq_if if_b ();

   assign if_a.start_i        = start;
   assign if_a.coarse_therm_i = coarse;
   assign if_a.fine_therm_i   = fine;
   assign if_b.start_i        = start;
   assign if_b.coarse_therm_i = coarse;
   assign if_b.fine_therm_i   = fine;

   two_step_seq #(.SAMPLE_CYC(A_S), .SETTLE_CYC(A_T)) dut_a (
      .clk_i(clk), .reset_ni(rst_n), .bus(if_a.slave));
   two_step_seq #(.SAMPLE_CYC(B_S), .SETTLE_CYC(B_T)) dut_b (
      .clk_i(clk), .reset_ni(rst_n), .bus(if_b.slave));

   wire [13:0] outs_a = {if_a.busy_o, if_a.sample_o, if_a.coarse_latch_o, if_a.fine_latch_o,
                         if_a.dac_code_o, if_a.msb_o, if_a.lsb_o, if_a.align_vld_o};
   wire [13:0] outs_b = {if_b.busy_o, if_b.sample_o, if_b.coarse_latch_o, if_b.fine_latch_o,
                         if_b.dac_code_o, if_b.msb_o, if_b.lsb_o, if_b.align_vld_o};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: optional majority filter by vote count, then highest set bit + 1.
   function automatic logic [2:0] model_code(input logic [6:0] t);
      logic [6:0] b;
      int code;
`ifdef TWO_STEP_BUBBLE_CORR_EN
      logic [8:0] x;
      x = {1'b0, t, 1'b1};
      for (int k = 0; k < 7; k++) b[k] = ((int'(x[k]) + int'(x[k+1]) + int'(x[k+2])) >= 2);
`else
      b = t;
`endif
      code = 0;
      for (int k = 0; k < 7; k++) if (b[k]) code = k + 1;
      return 3'(code);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Called at a negedge: presents inputs with start high, then consumes E0.
   task automatic launch(input logic [6:0] c, input logic [6:0] f, input bit expect_out);
      exp_t e;
      coarse = c;
      fine   = f;
      start  = 1'b1;
      @(posedge clk);
      #1;
      c0 = cyc;
      if (expect_out) begin
         e.msb = model_code(c);
         e.lsb = model_code(f);
         e.cyc = c0 + A_S + A_T + 4;
         q_a.push_back(e);
         e.cyc = c0 + B_S + B_T + 4;
         q_b.push_back(e);
      end
   endtask

   // Move to the negedge inside cycle k of the current conversion (cycle 1 follows E0).
   task automatic goto_cycle(input int k);
      do @(negedge clk); while (cyc < c0 + k - 1);
   endtask

   always @(negedge clk) begin : mon_a
      exp_t e;
      if (rst_n && if_a.align_vld_o) begin
         if (q_a.size() == 0) begin
            checks++; errors++;
            $display("FAIL vld_stray_a: got pulse at cycle %0d expected none", cyc);
         end else begin
            e = q_a.pop_front();
            chk("msb_at_vld_a", int'(if_a.msb_o), int'(e.msb));
            chk("lsb_at_vld_a", int'(if_a.lsb_o), int'(e.lsb));
            chk("vld_cycle_a", cyc, e.cyc);
         end
      end
   end

   always @(negedge clk) begin : mon_b
      exp_t e;
      if (rst_n && if_b.align_vld_o) begin
         if (q_b.size() == 0) begin
            checks++; errors++;
            $display("FAIL vld_stray_b: got pulse at cycle %0d expected none", cyc);
         end else begin
            e = q_b.pop_front();
            chk("msb_at_vld_b", int'(if_b.msb_o), int'(e.msb));
            chk("lsb_at_vld_b", int'(if_b.lsb_o), int'(e.lsb));
            chk("vld_cycle_b", cyc, e.cyc);
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [6:0] nc, nf;
      bit tog;

      // Reset values, then release with start low.
      repeat (3) @(negedge clk);
      chk("reset_outs_a", int'(outs_a), 0);
      chk("reset_outs_b", int'(outs_b), 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("idle_busy_a", int'(if_a.busy_o), 0);
      chk("idle_busy_b", int'(if_b.busy_o), 0);

      // Single conversion; start toggled during SETTLE must be ignored.
      @(negedge clk);
      launch(7'h1F, 7'h07, 1);
      goto_cycle(1);
      start = 1'b0;
      chk("sample_c1_a", int'(if_a.sample_o), 1);
      chk("busy_c1_a", int'(if_a.busy_o), 1);
      goto_cycle(2);
      chk("sample_c2_a", int'(if_a.sample_o), 1);
      chk("clatch_c2_b", int'(if_b.coarse_latch_o), 1);
      goto_cycle(3);
      chk("clatch_c3_a", int'(if_a.coarse_latch_o), 1);
      chk("dac_pre_e3_a", int'(if_a.dac_code_o), 0);
      chk("dac_after_e2_b", int'(if_b.dac_code_o), 5);
      goto_cycle(4);
      chk("dac_after_e3_a", int'(if_a.dac_code_o), 5);
      start = 1'b1;
      goto_cycle(5);
      start = 1'b1;
      goto_cycle(6);
      start = 1'b0;
      chk("flatch_c6_a", int'(if_a.fine_latch_o), 1);
      chk("msb_pre_e6_a", int'(if_a.msb_o), 0);
      chk("msb_pre_e6_b", int'(if_b.msb_o), 0);
      goto_cycle(7);
      chk("msb_after_e6_a", int'(if_a.msb_o), 5);
      chk("msb_after_e6_b", int'(if_b.msb_o), 5);
      chk("lsb_pre_e7_a", int'(if_a.lsb_o), 0);
      goto_cycle(8);
      chk("lsb_after_e7_a", int'(if_a.lsb_o), 3);
      chk("idle_after_lout_a", int'(if_a.busy_o), 0);
      goto_cycle(10);
      chk("no_extra_conv_a", int'(if_a.busy_o), 0);
      chk("no_extra_conv_b", int'(if_b.busy_o), 0);

      // Back-to-back with start held high.
      launch(7'h7F, 7'h00, 1);
      goto_cycle(7);
      chk("sample_in_lout_a", int'(if_a.sample_o), 0);
      launch(7'h00, 7'h7F, 1);
      goto_cycle(1);
      chk("sample_after_lout_a", int'(if_a.sample_o), 1);
      chk("sample_after_lout_b", int'(if_b.sample_o), 1);
      chk("busy_after_lout_a", int'(if_a.busy_o), 1);
      start = 1'b0;
      goto_cycle(8);
      chk("b2b_lsb_a", int'(if_a.lsb_o), 7);
      goto_cycle(10);

      // Bubble in the coarse bank.
      launch(7'b0010011, 7'h01, 1);
      goto_cycle(1);
      start = 1'b0;
      goto_cycle(7);
`ifdef TWO_STEP_BUBBLE_CORR_EN
      chk("bubble_msb_a", int'(if_a.msb_o), 2);
`else
      chk("bubble_msb_a", int'(if_a.msb_o), 5);
`endif
      goto_cycle(10);

      // Reset in SETTLE discards the conversion.
      launch(7'h3F, 7'h1F, 0);
      goto_cycle(1);
      start = 1'b0;
      goto_cycle(4);
      chk("dac_before_midreset_a", int'(if_a.dac_code_o), 6);
      rst_n = 1'b0;
      #1;
      chk("midreset_outs_a", int'(outs_a), 0);
      chk("midreset_outs_b", int'(outs_b), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_reset_busy_a", int'(if_a.busy_o), 0);
      launch(7'h0F, 7'h03, 1);
      goto_cycle(1);
      start = 1'b0;
      goto_cycle(8);
      chk("restart_msb_a", int'(if_a.msb_o), 4);
      chk("restart_lsb_a", int'(if_a.lsb_o), 2);
      goto_cycle(10);

      // Randomized conversions: raw or clean thermometer inputs, random gaps,
      // random start activity during the ignore window, random back-to-back.
      nc = 7'($urandom);
      nf = 7'($urandom);
      for (int n = 0; n < 40; n++) begin
         launch(nc, nf, 1);
         tog = 1'($urandom);
         for (int j = 1; j <= 6; j++) begin
            goto_cycle(j);
            start = tog ? 1'($urandom) : 1'b0;
         end
         goto_cycle(7);
         if ($urandom_range(0, 1) == 1) begin
            nc = 7'($urandom);
            nf = 7'($urandom);
         end else begin
            nc = 7'(7'h7F >> $urandom_range(0, 7));
            nf = 7'(7'h7F >> $urandom_range(0, 7));
         end
         if ($urandom_range(0, 1) == 1) begin
            start = 1'b1;
         end else begin
            start = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
      end
      start = 1'b0;

      for (int i = 0; i < 30 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
      chk("pending_a", q_a.size(), 0);
      chk("pending_b", q_b.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
